hazard_forward_ctrl: RTL

Parametrised hazard, forwarding and stall controller for the ARM pipeline, succeeding the stall-only hazard detector. It keeps its own scoreboard of in-flight destination registers for the stages ahead of ID and decides the ID-stage stall. It also produces per-source forwarding selects, freezes the pipeline while data memory is not ready, and keeps saturating stall/flush performance counters.

---
 rtl/hazard_forward_ctrl_pkg.sv | 30 +++
 rtl/hazard_forward_ctrl_match.sv | 44 ++++
 rtl/hazard_forward_ctrl.sv | 114 +++++++++++
 3 files changed

// File: rtl/hazard_forward_ctrl_pkg.sv
// Shared types and helpers for the hazard/forwarding controller: scoreboard
// entry layout, forwarding select encoding and counter saturation test.
package hazard_forward_ctrl_pkg;

    localparam int REG_AW_MAX = 16;
    localparam int CNT_W_MAX  = 32;
    localparam int FWD_RF     = 0;

    typedef struct packed {
        logic                  valid;
        logic [REG_AW_MAX-1:0] dest;
        logic                  wb_en;
        logic                  mem_r_en;
    } sb_entry_t;

    // True when the low 'width' bits of cnt are all ones, i.e. the counter is saturated.
    function automatic logic cnt_at_max(input logic [CNT_W_MAX-1:0] cnt, input int width);
        logic all_ones;
        all_ones = 1'b1;
        for (int i = 0; i < CNT_W_MAX; i++) begin
            if ((i < width) && !cnt[i]) begin
                all_ones = 1'b0;
            end else begin
                all_ones = all_ones;
            end
        end
        return all_ones;
    endfunction

endpackage

// File: rtl/hazard_forward_ctrl_match.sv
// Priority match of one ID source against the in-flight scoreboard entries;
// yields a stall request and the forwarding select for that source.
module hazard_match
    import hazard_forward_ctrl_pkg::*;
#(
    parameter int REG_AW         = 4,
    parameter int STAGES         = 3,
    parameter bit FWD_EN         = 1'b1,
    parameter int LOAD_FWD_STAGE = 1,
    parameter int SEL_W          = $clog2(STAGES + 1)
) (
    input  logic                     src_use_i,
    input  logic [REG_AW-1:0]        src_i,
    input  sb_entry_t [STAGES-1:0]   ents_i,
    output logic                     stall_o,
    output logic [SEL_W-1:0]         sel_o
);

    // Walk from oldest to youngest so the lowest matching index has the last word.
    always_comb begin
        stall_o = 1'b0;
        sel_o   = SEL_W'(FWD_RF);
        for (int i = STAGES - 1; i >= 0; i--) begin
            if (src_use_i && ents_i[i].valid && ents_i[i].wb_en &&
                (ents_i[i].dest == REG_AW_MAX'(src_i))) begin
                if (FWD_EN) begin
                    if (ents_i[i].mem_r_en && (i < LOAD_FWD_STAGE)) begin
                        stall_o = 1'b1;
                        sel_o   = SEL_W'(FWD_RF);
                    end else begin
                        stall_o = 1'b0;
                        sel_o   = SEL_W'(i + 1);
                    end
                end else begin
                    // The WB entry writes through the register file, so it never stalls.
                    stall_o = stall_o | (i <= STAGES - 2);
                end
            end else begin
                stall_o = stall_o;
            end
        end
    end

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Hazard, forwarding and stall controller: tracks in-flight destinations ahead
// of ID, decides the ID stall, forwarding selects, memory freeze and perf counters.
module hazard_forward_ctrl
    import hazard_forward_ctrl_pkg::*;
#(
    parameter int REG_AW         = 4,
    parameter int STAGES         = 3,
    parameter bit FWD_EN         = 1'b1,
    parameter int LOAD_FWD_STAGE = 1,
    parameter int CNT_W          = 16,
    parameter int SEL_W          = $clog2(STAGES + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_src1,
    input  logic [REG_AW-1:0] id_src2,
    input  logic              id_use_src1,
    input  logic              id_two_src,
    input  logic [REG_AW-1:0] id_dest,
    input  logic              id_wb_en,
    input  logic              id_mem_r_en,
    input  logic              branch_taken,
    input  logic              mem_ready,
    input  logic              mem_busy_req,
    output logic              freeze_front,
    output logic              freeze_back,
    output logic              hazard,
    output logic [SEL_W-1:0]  fwd_sel1,
    output logic [SEL_W-1:0]  fwd_sel2,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    sb_entry_t [STAGES-1:0] sb_q, sb_d;
    logic [CNT_W-1:0]       stall_q, stall_d, flush_q, flush_d;
    logic                   mem_stall_s, flush_s, hazard_s, stall1_s, stall2_s;
    logic [SEL_W-1:0]       sel1_s, sel2_s;

    hazard_match #(.REG_AW(REG_AW), .STAGES(STAGES), .FWD_EN(FWD_EN),
                   .LOAD_FWD_STAGE(LOAD_FWD_STAGE), .SEL_W(SEL_W)) u_match1 (
        .src_use_i(id_use_src1), .src_i(id_src1), .ents_i(sb_q),
        .stall_o(stall1_s), .sel_o(sel1_s)
    );

    hazard_match #(.REG_AW(REG_AW), .STAGES(STAGES), .FWD_EN(FWD_EN),
                   .LOAD_FWD_STAGE(LOAD_FWD_STAGE), .SEL_W(SEL_W)) u_match2 (
        .src_use_i(id_two_src), .src_i(id_src2), .ents_i(sb_q),
        .stall_o(stall2_s), .sel_o(sel2_s)
    );

    assign mem_stall_s = mem_busy_req & ~mem_ready;
    assign flush_s     = branch_taken & ~mem_stall_s;
    assign hazard_s    = (stall1_s | stall2_s) & id_valid & ~flush_s;

    // Outputs are forced low while reset is held, independent of the clock.
    assign hazard       = rst & hazard_s;
    assign freeze_front = rst & (hazard_s | mem_stall_s);
    assign freeze_back  = rst & mem_stall_s;
    assign fwd_sel1     = rst ? sel1_s : SEL_W'(FWD_RF);
    assign fwd_sel2     = rst ? sel2_s : SEL_W'(FWD_RF);
    assign stall_cnt    = stall_q;
    assign flush_cnt    = flush_q;

    // Scoreboard next state: hold on memory stall, else shift with bubble or ID fields.
    always_comb begin
        sb_d = sb_q;
        if (mem_stall_s) begin
            sb_d = sb_q;
        end else begin
            for (int i = 1; i < STAGES; i++) begin
                sb_d[i] = sb_q[i-1];
            end
            if (flush_s || hazard_s) begin
                sb_d[0] = '0;
            end else begin
                sb_d[0].valid    = id_valid;
                sb_d[0].dest     = REG_AW_MAX'(id_dest);
                sb_d[0].wb_en    = id_wb_en;
                sb_d[0].mem_r_en = id_mem_r_en;
            end
        end
    end

    // Saturating performance counters.
    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if ((hazard_s || mem_stall_s) && !cnt_at_max(CNT_W_MAX'(stall_q), CNT_W)) begin
            stall_d = stall_q + CNT_W'(1);
        end else begin
            stall_d = stall_q;
        end
        if (flush_s && !cnt_at_max(CNT_W_MAX'(flush_q), CNT_W)) begin
            flush_d = flush_q + CNT_W'(1);
        end else begin
            flush_d = flush_q;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sb_q    <= '0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            sb_q    <= sb_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

endmodule
